// File: rtl/rv32_pkg.sv
// Shared rv32 types for the data-memory path plus the arbiter's state and
// owner encodings.
package rv32_pkg;

  localparam int unsigned DMEM_AW = 12;

  typedef logic [DMEM_AW-1:0] rv_dmem_addr_t;
  typedef logic [31:0]        rv32_data_t;

  typedef enum logic {
    NORMAL,
    BOOST
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE,
    OWNER_HOST
  } dmem_owner_e;

endpackage

// File: rtl/rv32_dmem_arb.sv
// Two-requester data-memory arbiter: core has priority, host is protected from
// starvation by a one-cycle BOOST window, and host owns memory in programming mode.
module rv32_dmem_arb
  import rv32_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  rv_dmem_addr_t core_addr,
  input  rv32_data_t    core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output rv32_data_t    core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  rv_dmem_addr_t host_addr,
  input  rv32_data_t    host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output rv32_data_t    host_rdata,
  input  logic          host_program,
  output rv_dmem_addr_t mem_addr,
  output rv32_data_t    mem_wdata,
  output logic          mem_wen,
  input  rv32_data_t    mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  arb_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        rd_pend_q;
  dmem_owner_e owner_q;

  // Grants are gated by rst_n so nothing reaches the BRAM while reset is held.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      if (host_program) begin
        host_gnt = host_req;
      end else if (state_q == BOOST) begin
        host_gnt = host_req;
        core_gnt = core_req & ~host_req;
      end else begin
        core_gnt = core_req;
        host_gnt = host_req & ~core_req;
      end
    end
  end

  // BOOST and programming mode both fall back to NORMAL with a cleared counter.
  always_comb begin
    state_d = NORMAL;
    cnt_d   = '0;
    if (!host_program && state_q == NORMAL && host_req && !host_gnt) begin
      if (cnt_q == CNT_LAST) begin
        state_d = BOOST;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_wen   = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_gnt) begin
      mem_wen   = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      owner_q   <= OWNER_CORE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= (core_gnt & ~core_we) | (host_gnt & ~host_we);
      owner_q   <= host_gnt ? OWNER_HOST : OWNER_CORE;
    end
  end

  assign core_rvalid = rd_pend_q && (owner_q == OWNER_CORE);
  assign host_rvalid = rd_pend_q && (owner_q == OWNER_HOST);
  assign core_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_rv32_dmem_arb.sv
// Scoreboard bench for rv32_dmem_arb: a reference arbitration model plus a
// BRAM model; load responses are queued at grant time and checked by a monitor.
module tb_rv32_dmem_arb;
  import rv32_pkg::*;

  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  rv_dmem_addr_t core_addr = '0;
  rv32_data_t    core_wdata = '0;
  logic          core_gnt, core_rvalid;
  rv32_data_t    core_rdata;
  logic          host_req = 1'b0, host_we = 1'b0;
  rv_dmem_addr_t host_addr = '0;
  rv32_data_t    host_wdata = '0;
  logic          host_gnt, host_rvalid;
  rv32_data_t    host_rdata;
  logic          host_program = 1'b0;
  rv_dmem_addr_t mem_addr;
  rv32_data_t    mem_wdata;
  logic          mem_wen;
  rv32_data_t    mem_rdata;

  rv32_dmem_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_program(host_program),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model: read-first, data one cycle after address.
  logic [31:0] bram [0:4095];
  always @(posedge clk) begin
    if (mem_wen) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  typedef struct {
    int unsigned due;
    bit          to_host;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [0:4095];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          denied = 0;
  bit          boost = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    denied = 0;
    boost = 1'b0;
    exp_q.delete();
  endtask

  // One arbitration cycle: drive, check grants and memory port, update the model.
  task automatic step(input bit cr, input bit cw, input logic [11:0] ca, input logic [31:0] cd,
                      input bit hr, input bit hw, input logic [11:0] ha, input logic [31:0] hd,
                      input bit hp);
    bit eg_c, eg_h, we;
    logic [11:0] a;
    logic [31:0] d;
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    host_program = hp;
    #1;
    if (hp) begin
      eg_h = hr; eg_c = 1'b0;
    end else if (boost) begin
      eg_h = hr; eg_c = cr && !hr;
    end else begin
      eg_c = cr; eg_h = hr && !cr;
    end
    we = eg_c ? cw : (eg_h ? hw : 1'b0);
    a  = eg_c ? ca : (eg_h ? ha : 12'h0);
    d  = eg_c ? cd : (eg_h ? hd : 32'h0);
    chk("core_gnt", core_gnt, eg_c);
    chk("host_gnt", host_gnt, eg_h);
    chk("mem_wen", mem_wen, we);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    if (eg_c || eg_h) begin
      if (we) ref_mem[a] = d;
      else exp_q.push_back('{due: cyc + 1, to_host: eg_h, data: ref_mem[a]});
    end
    // Host gets a guaranteed turn once it has been refused STARVE_MAX times in a row.
    if (hp || boost) begin
      denied = 0; boost = 1'b0;
    end else if (hr && !eg_h) begin
      denied++;
      if (denied >= SM) begin
        boost = 1'b1; denied = 0;
      end
    end else begin
      denied = 0;
    end
  endtask

  task automatic idle();
    step(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
  endtask

  // Monitor: exactly the owner of a response due this cycle sees rvalid.
  initial begin
    forever begin
      bit ec, eh;
      logic [31:0] ed;
      @(negedge clk);
      ec = 0; eh = 0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        ec = !exp_q[0].to_host;
        eh = exp_q[0].to_host;
        ed = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      chk("core_rvalid", core_rvalid, ec);
      chk("host_rvalid", host_rvalid, eh);
      if (ec) chk("core_rdata", core_rdata, ed);
      if (eh) chk("host_rdata", host_rdata, ed);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit prog;
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 'h010) v = 32'hDEADBEEF;
      bram[i] <= v;
      ref_mem[i] = v;
    end
    #2 rst_n = 1'b0;
    core_req = 1'b1; host_req = 1'b1;
    #3;
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_mem_wen", mem_wen, 0);
    @(negedge clk);
    core_req = 1'b0; host_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_core_gnt", core_gnt, 0);
    chk("rel_host_gnt", host_gnt, 0);

    // Core-only load of a preloaded word.
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    idle();

    // Continuous contention: host wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 12'h001, 32'h0, 1, 0, 12'h002, 32'h0, 0);
      chk("starve_core", core_gnt, (i % 5) != 4);
      chk("starve_host", host_gnt, (i % 5) == 4);
    end
    idle();

    // Programming mode: only the host store lands, then read it back.
    step(1, 1, 12'h020, 32'h11, 1, 1, 12'h020, 32'h22, 1);
    step(1, 0, 12'h020, 32'h0, 1, 0, 12'h020, 32'h0, 1);
    chk("prog_core_blocked", core_gnt, 0);
    idle();

    // Store then load to the same address returns the new value via the BRAM.
    step(1, 1, 12'h030, 32'h55, 0, 0, 12'h0, 32'h0, 0);
    step(1, 0, 12'h030, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    idle();

    // Back-to-back loads alternating owners, with programming toggling mid-flight.
    step(1, 0, 12'h003, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    step(1, 0, 12'h004, 32'h0, 1, 0, 12'h005, 32'h0, 1);
    step(1, 0, 12'h006, 32'h0, 0, 0, 12'h0, 32'h0, 0);
    idle();

    // Randomized traffic on a small address window to force collisions.
    prog = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) prog = !prog;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 12'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 12'($urandom_range(0, 15)), $urandom,
           prog);
    end
    idle();

    // Host load, then reset the next cycle: the response is discarded.
    step(0, 0, 12'h0, 32'h0, 1, 0, 12'h007, 32'h0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    repeat (2) @(negedge clk);
    core_req = 1'b0; host_req = 1'b0; host_program = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", {core_gnt, host_gnt, mem_wen}, 0);
    chk("post_rst_addr", mem_addr, 0);
    repeat (3) idle();

    repeat (2) idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
